// File: rtl/dp_ram_pkg.sv
// dp_ram_pkg: shared types and helpers for the true dual-port RAM.
// Byte merge is sized to MAX_DW; callers cast to/from their word width.
package dp_ram_pkg;

   localparam int MAX_DW = 512;
   localparam int MAX_BE = MAX_DW / 8;

   typedef enum logic {
      RDW_READ_FIRST  = 1'b0,
      RDW_WRITE_FIRST = 1'b1
   } rdw_mode_e;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } ram_state_e;

   function automatic logic [MAX_DW-1:0] byte_merge(
      input logic [MAX_DW-1:0] old,
      input logic [MAX_DW-1:0] wdata,
      input logic [MAX_BE-1:0] be
   );
      logic [MAX_DW-1:0] r;
      r = old;
      for (int i = 0; i < MAX_BE; i++) begin
         if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/dp_ram_tdp_if.sv
// dp_ram_tdp_if: one RAM port (request + registered read response).
// master drives requests, slave (the RAM) returns rdata/rvalid.
interface dp_ram_tdp_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) ();

   logic                    en;
   logic                    we;
   logic [DATA_WIDTH/8-1:0] be;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH-1:0]   rdata;
   logic                    rvalid;

   modport master (
      output en, we, be, addr, wdata,
      input  rdata, rvalid
   );

   modport slave (
      input  en, we, be, addr, wdata,
      output rdata, rvalid
   );

endinterface

// File: rtl/dp_ram_rd_pipe.sv
// dp_ram_rd_pipe: 1- or 2-cycle read-data delay line with rvalid.
// rdata only updates on a valid beat and holds otherwise.
module dp_ram_rd_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic                  s_valid;
   logic [DATA_WIDTH-1:0] s_data;

   if (RD_LATENCY == 2) begin : g_lat2
      logic                  v1;
      logic [DATA_WIDTH-1:0] d1;

      // extra stage for the two-cycle read path
      always_ff @(posedge clk) begin
         if (rst) begin
            v1 <= 1'b0;
            d1 <= '0;
         end else begin
            v1 <= in_valid;
            d1 <= in_data;
         end
      end

      assign s_valid = v1;
      assign s_data  = d1;
   end else begin : g_lat1
      assign s_valid = in_valid;
      assign s_data  = in_data;
   end

   // output register: pulse rvalid, hold rdata between reads
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= s_valid;
         if (s_valid) out_data <= s_data;
      end
   end

endmodule

// File: rtl/dp_ram_tdp.sv
// dp_ram_tdp: true dual-port RAM, byte enables, registered reads,
// selectable cross-port RDW, A-wins write merge, optional zero-fill.
module dp_ram_tdp
   import dp_ram_pkg::*;
#(
   parameter int ADDR_WIDTH    = 8,
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 1 << ADDR_WIDTH,
   parameter int RD_LATENCY    = 1,
   parameter int RDW_MODE      = 0,
   parameter int INIT_ON_RESET = 1
) (
   input  logic         clk,
   input  logic         rst,
   output logic         init_busy,
   output logic         collision,
   dp_ram_tdp_if.slave  a,
   dp_ram_tdp_if.slave  b
);

   localparam int BW = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
   localparam rdw_mode_e MODE =
      (RDW_MODE != 0) ? RDW_WRITE_FIRST : RDW_READ_FIRST;

   if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_DW) begin : g_bad_dw
      $error("dp_ram_tdp: DATA_WIDTH must be a multiple of 8");
   end
   if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
      $error("dp_ram_tdp: RD_LATENCY must be 1 or 2");
   end
   if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
      $error("dp_ram_tdp: DEPTH out of range for ADDR_WIDTH");
   end

   function automatic logic [DATA_WIDTH-1:0] merge(
      input logic [DATA_WIDTH-1:0] old,
      input logic [DATA_WIDTH-1:0] wd,
      input logic [BW-1:0]         be
   );
      return DATA_WIDTH'(byte_merge(MAX_DW'(old), MAX_DW'(wd), MAX_BE'(be)));
   endfunction

   ram_state_e            state;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  ready;
   logic                  a_ok, b_ok, same;
   logic                  a_wr, b_wr, b_wr_own;
   logic                  a_rd, b_rd;
   logic [DATA_WIDTH-1:0] a_old, b_old, a_new, b_new;
   logic [DATA_WIDTH-1:0] a_rword, b_rword;

   // request decode, merged write words and read-during-write select
   always_comb begin
      ready    = (state == ST_READY) && !rst;
      a_ok     = 32'(a.addr) < DEPTH;
      b_ok     = 32'(b.addr) < DEPTH;
      same     = a.addr == b.addr;
      a_wr     = ready && a.en && a.we && a_ok;
      b_wr     = ready && b.en && b.we && b_ok;
      a_rd     = ready && a.en && !a.we;
      b_rd     = ready && b.en && !b.we;
      a_old    = a_ok ? mem[a.addr] : '0;
      b_old    = b_ok ? mem[b.addr] : '0;
      b_new    = merge(b_old, b.wdata, b.be);
      a_new    = merge((b_wr && same) ? b_new : a_old, a.wdata, a.be);
      b_wr_own = b_wr && !(a_wr && same);
      a_rword  = a_old;
      b_rword  = b_old;
      if (MODE == RDW_WRITE_FIRST) begin
         if (b_wr && same) a_rword = b_new;
         if (a_wr && same) b_rword = a_new;
      end
   end

   // storage: zero-fill during INIT, else the merged port writes
   always_ff @(posedge clk) begin
      if (state == ST_INIT && !rst) mem[cnt] <= '0;
      if (a_wr) mem[a.addr] <= a_new;
      if (b_wr_own) mem[b.addr] <= b_new;
   end

   // INIT/READY sequencer with registered init_busy
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
         cnt       <= '0;
         init_busy <= INIT_ON_RESET != 0;
      end else if (state == ST_INIT) begin
         if (cnt == LAST) begin
            state     <= ST_READY;
            init_busy <= 1'b0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // flag same-address writes that fight over at least one byte
   always_ff @(posedge clk) begin
      if (rst) collision <= 1'b0;
      else collision <= a_wr && b_wr && same && |(a.be & b.be);
   end

   dp_ram_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (a_rd),
      .in_data   (a_rword),
      .out_valid (a.rvalid),
      .out_data  (a.rdata)
   );

   dp_ram_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (b_rd),
      .in_data   (b_rword),
      .out_valid (b.rvalid),
      .out_data  (b.rdata)
   );

endmodule

// File: tb/tb_dp_ram_tdp.sv
// tb_dp_ram_tdp: two RAM instances (lat1/read-first/256, lat2/write-first/200)
// driven with identical stimulus and checked against a reference model.
module tb_dp_ram_tdp;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks   = 0;
   int failures = 0;

   dp_ram_tdp_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) pa0 ();
   dp_ram_tdp_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) pb0 ();
   dp_ram_tdp_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) pa1 ();
   dp_ram_tdp_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) pb1 ();

   logic [1:0] busy, col;

   dp_ram_tdp #(
      .ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(256),
      .RD_LATENCY(1), .RDW_MODE(0), .INIT_ON_RESET(1)
   ) dut0 (
      .clk(clk), .rst(rst), .init_busy(busy[0]), .collision(col[0]),
      .a(pa0.slave), .b(pb0.slave)
   );

   dp_ram_tdp #(
      .ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(200),
      .RD_LATENCY(2), .RDW_MODE(1), .INIT_ON_RESET(1)
   ) dut1 (
      .clk(clk), .rst(rst), .init_busy(busy[1]), .collision(col[1]),
      .a(pa1.slave), .b(pb1.slave)
   );

   logic [3:0]  rv;
   logic [31:0] rd [4];
   assign rv    = {pb1.rvalid, pa1.rvalid, pb0.rvalid, pa0.rvalid};
   assign rd[0] = pa0.rdata;
   assign rd[1] = pb0.rdata;
   assign rd[2] = pa1.rdata;
   assign rd[3] = pb1.rdata;

   typedef struct {
      int          port;
      logic [31:0] d;
      int          due;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mm [2][256];

   function automatic logic [31:0] mrg(logic [31:0] o, logic [31:0] w,
                                       logic [3:0] be);
      logic [31:0] m;
      m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (o & ~m) | (w & m);
   endfunction

   task automatic drive(
      input logic ae, awe, input logic [3:0] abe,
      input logic [7:0] aad, input logic [31:0] awd,
      input logic ben, bwe, input logic [3:0] bbe,
      input logic [7:0] bad, input logic [31:0] bwd
   );
      pa0.en = ae;  pa0.we = awe; pa0.be = abe; pa0.addr = aad; pa0.wdata = awd;
      pa1.en = ae;  pa1.we = awe; pa1.be = abe; pa1.addr = aad; pa1.wdata = awd;
      pb0.en = ben; pb0.we = bwe; pb0.be = bbe; pb0.addr = bad; pb0.wdata = bwd;
      pb1.en = ben; pb1.we = bwe; pb1.be = bbe; pb1.addr = bad; pb1.wdata = bwd;
   endtask

   // one cycle of traffic on both instances; live=0 means RAM is in INIT
   task automatic op(
      input bit live,
      input logic ae, awe, input logic [3:0] abe,
      input logic [7:0] aad, input logic [31:0] awd,
      input logic ben, bwe, input logic [3:0] bbe,
      input logic [7:0] bad, input logic [31:0] bwd
   );
      logic [1:0] ecol;
      ecol = 2'b00;
      drive(ae, awe, abe, aad, awd, ben, bwe, bbe, bad, bwd);
      if (live) begin
         for (int k = 0; k < 2; k++) begin
            int          dep, lat;
            bit          wf, aw, bw, same;
            logic [31:0] oa, ob;
            exp_t        e;
            dep  = (k == 0) ? 256 : 200;
            lat  = (k == 0) ? 1 : 2;
            wf   = (k == 1);
            aw   = ae && awe && (int'(aad) < dep);
            bw   = ben && bwe && (int'(bad) < dep);
            same = (aad == bad);
            oa   = (int'(aad) < dep) ? mm[k][aad] : 32'h0;
            ob   = (int'(bad) < dep) ? mm[k][bad] : 32'h0;
            if (ae && !awe) begin
               e.port = 2 * k;
               e.d    = (wf && bw && same) ? mrg(oa, bwd, bbe) : oa;
               e.due  = cyc + lat;
               q.push_back(e);
            end
            if (ben && !bwe) begin
               e.port = 2 * k + 1;
               e.d    = (wf && aw && same) ? mrg(ob, awd, abe) : ob;
               e.due  = cyc + lat;
               q.push_back(e);
            end
            ecol[k] = aw && bw && same && ((abe & bbe) != 4'h0);
            if (bw) mm[k][bad] = mrg(mm[k][bad], bwd, bbe);
            if (aw) mm[k][aad] = mrg(mm[k][aad], awd, abe);
         end
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (col[k] !== ecol[k]) begin
            failures++;
            $display("FAIL collision dut%0d got=%b expected=%b t=%0d",
                     k, col[k], ecol[k], cyc);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) op(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic rd2(input logic [7:0] aad, input logic [7:0] bad);
      op(1, 1, 0, 4'h0, aad, 0, 1, 0, 4'h0, bad, 0);
   endtask

   task automatic wr_a(input logic [7:0] ad, input logic [31:0] d,
                       input logic [3:0] be);
      op(1, 1, 1, be, ad, d, 0, 0, 0, 0, 0);
   endtask

   // read scoreboard: data and arrival cycle must both match
   always @(negedge clk) begin
      for (int p = 0; p < 4; p++) begin
         if (rv[p]) begin
            int idx;
            idx = -1;
            for (int i = 0; i < q.size(); i++) begin
               if (q[i].port == p) begin
                  idx = i;
                  break;
               end
            end
            checks++;
            if (idx < 0) begin
               failures++;
               $display("FAIL rvalid_unexpected port=%0d got=%h t=%0d",
                        p, rd[p], cyc);
            end else begin
               if (rd[p] !== q[idx].d || cyc != q[idx].due) begin
                  failures++;
                  $display("FAIL read port=%0d got=%h@%0d expected=%h@%0d",
                           p, rd[p], cyc, q[idx].d, q[idx].due);
               end
               q.delete(idx);
            end
         end
      end
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].due < cyc) begin
            checks++;
            failures++;
            $display("FAIL read_missing port=%0d expected=%h@%0d",
                     q[i].port, q[i].d, q[i].due);
            q.delete(i);
         end
      end
   end

   task automatic count_init(input bit poke, output int n0, output int n1);
      n0 = 0;
      n1 = 0;
      for (int t = 0; t < 1000 && busy != 2'b00; t++) begin
         if (busy[0]) n0++;
         if (busy[1]) n1++;
         if (poke && t >= 5 && t < 9)
            op(0, 1, 1, 4'hF, 8'd3, 32'hDEAD0000 | t, 1, 0, 4'h0, 8'd4, 0);
         else
            op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      for (int p = 0; p < 4; p++) begin
         checks++;
         if (rv[p] !== 1'b0 || rd[p] !== 32'h0) begin
            failures++;
            $display("FAIL reset_rd port=%0d got=%b/%h expected=0/0",
                     p, rv[p], rd[p]);
         end
      end
      checks++;
      if (col !== 2'b00 || busy !== 2'b11) begin
         failures++;
         $display("FAIL reset_flags got col=%b busy=%b expected col=00 busy=11",
                  col, busy);
      end
   endtask

   task automatic test_init;
      int n0, n1;
      rst = 1'b0;
      count_init(0, n0, n1);
      checks++;
      if (n0 != 256 || n1 != 200) begin
         failures++;
         $display("FAIL init_len got=%0d/%0d expected=256/200", n0, n1);
      end
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 256; i++) mm[k][i] = 32'h0;
      rd2(8'hFF, 8'h00);
      idle(3);
   endtask

   task automatic test_reset_mid_init;
      int n0, n1, hi;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      hi = 0;
      for (int i = 0; i < 100; i++) begin
         if (busy == 2'b11) hi++;
         op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (hi != 100 || busy !== 2'b11) begin
         failures++;
         $display("FAIL init_hold got=%0d busy=%b expected=100 busy=11",
                  hi, busy);
      end
      rst = 1'b0;
      count_init(1, n0, n1);
      checks++;
      if (n0 != 256 || n1 != 200) begin
         failures++;
         $display("FAIL init_restart got=%0d/%0d expected=256/200", n0, n1);
      end
      rd2(8'd3, 8'd4);
      idle(3);
   endtask

   task automatic test_byte_enables;
      wr_a(8'd5, 32'hAABBCCDD, 4'hF);
      wr_a(8'd5, 32'h11223344, 4'h5);
      rd2(8'd5, 8'd5);
      op(1, 1, 1, 4'h0, 8'd5, 32'hFFFFFFFF, 1, 0, 4'h0, 8'd5, 0);
      idle(3);
   endtask

   task automatic test_back_to_back;
      op(1, 1, 1, 4'hF, 8'd1, 32'h0101A001, 1, 1, 4'hF, 8'd2, 32'h0202B002);
      wr_a(8'd3, 32'h0303C003, 4'hF);
      rd2(8'd1, 8'd3);
      rd2(8'd2, 8'd2);
      rd2(8'd3, 8'd1);
      idle(4);
      checks++;
      if (rd[0] !== 32'h0303C003 || rv[0] !== 1'b0 ||
          rd[2] !== 32'h0303C003 || rv[2] !== 1'b0) begin
         failures++;
         $display("FAIL rdata_hold got=%h/%h expected=0303c003/0303c003",
                  rd[0], rd[2]);
      end
   endtask

   task automatic test_rdw;
      wr_a(8'd7, 32'h1, 4'hF);
      op(1, 1, 1, 4'hF, 8'd7, 32'h2, 1, 0, 4'h0, 8'd7, 0);
      op(1, 1, 0, 4'h0, 8'd7, 0, 1, 1, 4'h8, 8'd7, 32'hAB000000);
      idle(3);
   endtask

   task automatic test_collision;
      op(1, 1, 1, 4'h3, 8'd9, 32'hFFFFFFFF, 1, 1, 4'h6, 8'd9, 32'h0);
      idle(1);
      rd2(8'd9, 8'd9);
      op(1, 1, 1, 4'h3, 8'd9, 32'hFFFFFFFF, 1, 1, 4'hC, 8'd9, 32'h0);
      rd2(8'd9, 8'd9);
      op(1, 1, 1, 4'hF, 8'd10, 32'h5, 1, 1, 4'hF, 8'd11, 32'h6);
      rd2(8'd10, 8'd11);
      idle(3);
   endtask

   task automatic test_out_of_range;
      op(1, 1, 1, 4'hF, 8'd220, 32'h12345678, 1, 1, 4'hF, 8'd250, 32'hCAFEF00D);
      rd2(8'd220, 8'd250);
      op(1, 1, 1, 4'hF, 8'd199, 32'h0BADBEEF, 1, 0, 4'h0, 8'd200, 0);
      rd2(8'd199, 8'd255);
      idle(3);
   endtask

   task automatic test_random;
      for (int i = 0; i < 80; i++) begin
         logic [31:0] r, wa, wb;
         logic [7:0]  aa, ab;
         r  = $urandom;
         wa = $urandom;
         wb = $urandom;
         aa = (r[26:24] == 3'd0) ? 8'(195 + r[15:10]) : {4'h0, r[19:16]};
         ab = (r[29:27] == 3'd0) ? 8'(195 + r[9:4])   : {4'h0, r[23:20]};
         if (r[30]) ab = aa;
         op(1, r[0], r[1], r[5:2], aa, wa, r[6], r[7], r[11:8], ab, wb);
      end
      idle(4);
   endtask

   initial begin
      test_reset;
      test_init;
      test_reset_mid_init;
      test_byte_enables;
      test_back_to_back;
      test_rdw;
      test_collision;
      test_out_of_range;
      test_random;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d pending expected=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dp_ram_tdp.md
Name: dp_ram_tdp

Overview:
Parametrised true dual-port RAM and the successor to the team's existing single-clock dual-port memory. Adds byte-enable writes, registered reads with 1 or 2 cycles of latency and an rvalid handshake, and a selectable cross-port read-during-write policy. Same-address write conflicts are resolved deterministically and flagged. An optional zero-fill sequencer clears the array after reset. Used as register-file / buffer storage behind the processor and SPI datapaths.

Parameters:
ADDR_WIDTH, 8, address bits per port
DATA_WIDTH, 32, word width; must be a multiple of 8
DEPTH, 1<<ADDR_WIDTH, number of words; must be <= 2**ADDR_WIDTH
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2
RDW_MODE, 0, cross-port read-during-write: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new data)
INIT_ON_RESET, 1, 1 = zero-fill the array after reset

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
init_busy  out  1  high while zero-fill is in progress
a_en  in  1  port A request
a_we  in  1  port A write (1) / read (0)
a_be  in  DATA_WIDTH/8  port A byte enables (writes only)
a_addr  in  ADDR_WIDTH  port A address
a_wdata  in  DATA_WIDTH  port A write data
a_rdata  out  DATA_WIDTH  port A read data
a_rvalid  out  1  port A read data valid, one-cycle pulse per read
b_en, b_we, b_be, b_addr, b_wdata, b_rdata, b_rvalid  same widths and meanings, port B
collision  out  1  one-cycle pulse on a same-address, overlapping-byte write conflict

Behaviour:
- Reset (rst=1 at a clk edge): a_rdata/b_rdata=0, a_rvalid/b_rvalid=0, collision=0, read pipelines flushed. With INIT_ON_RESET=1: FSM enters INIT, init_busy=1. With INIT_ON_RESET=0: FSM enters READY, init_busy=0, array contents unchanged.
- FSM has two states, INIT and READY.
  - INIT: writes 0 to mem[cnt] each cycle with cnt running 0..DEPTH-1. After the write at DEPTH-1, the FSM moves to READY. init_busy falls the cycle READY is entered, so init_busy is high for exactly DEPTH cycles.
  - While in INIT, all port requests are ignored: no writes, no rvalid.
  - rst asserted mid-INIT restarts cnt at 0.
- Read (en=1, we=0, READY):
  - RD_LATENCY=1: rdata is valid and rvalid=1 on the cycle after the request edge.
  - RD_LATENCY=2: one cycle later than above.
  - Back-to-back reads are fully pipelined at one per cycle per port.
  - rdata holds its last value while rvalid=0.
- Write (en=1, we=1, READY): for each byte i with be[i]=1, mem[addr] byte i takes wdata byte i; other bytes are kept. Writes never produce rvalid. be=0 is a legal no-op.
- Cross-port read-during-write (one port writes address X while the other reads X in the same cycle):
  - READ_FIRST: the reader gets the pre-write word.
  - WRITE_FIRST: the reader gets the post-write word, byte-merged.
- Both ports write the same address in the same cycle:
  - Bytes enabled on only one port take that port's data.
  - Bytes enabled on both ports take port A's data.
  - collision pulses for 1 cycle on the next edge if (a_be & b_be) != 0.
  - Simultaneous reads of the same address: no collision, both return the word.
- Out-of-range address (addr >= DEPTH): writes are dropped; reads return 0 with rvalid asserted normally.
- DATA_WIDTH%8 != 0, or RD_LATENCY not in {1,2}: elaboration-time $error.

Decomposition:
- Package dp_ram_pkg:
  - rdw_mode_e enum (RDW_READ_FIRST, RDW_WRITE_FIRST)
  - ram_state_e enum (ST_INIT, ST_READY)
  - function byte_merge(old, wdata, be) for the byte-enable merge
- Sub-module dp_ram_rd_pipe, parameterised on DATA_WIDTH and RD_LATENCY. It provides the rdata/rvalid delay pipeline with synchronous clear and is instantiated once per port.

Test Plan:
- Init: INIT_ON_RESET=1, DEPTH=256, release rst -> init_busy high for exactly 256 cycles; then a read of addr 0xFF returns 0x00000000, rvalid 1 cycle later.
- Byte enables: A writes 0xAABBCCDD to addr 5 with be=4'b1111, then 0x11223344 with be=4'b0101 -> read of addr 5 returns 0xAA22CC44.
- Latency: RD_LATENCY=2, reads of addrs 1,2,3 on consecutive cycles -> rvalid high on cycles +2,+3,+4 with the matching words, no bubbles.
- RDW: mem[7]=0x1, A writes 0x2 to addr 7 while B reads addr 7 -> B gets 0x1 with RDW_MODE=0, 0x2 with RDW_MODE=1.
- Collision: A writes 0xFFFFFFFF be=4'b0011, B writes 0x00000000 be=4'b0110, both to addr 9 -> mem[9]=0x0000FFFF and collision pulses once; repeat with B be=4'b1100 -> mem[9]=0x0000FFFF and no collision.
- Reset mid-init: assert rst at init cycle 100 -> init_busy stays high, exactly 256 further cycles to READY; requests issued during INIT produce no rvalid and no writes.
